rtc_bus_responder: RTL and testbench
====================================

// Module: rtc_bus_responder
// PURPOSE
//  Synthesizable responder (slave) for the multiplexed RTC bus (ChipSelect/Read/Write/AoD + 8-bit data/address).
//  Answers the RTC protocol initiator exactly as the external RTC chip does, for on-board self-test and closed-loop simulation.
//  Holds 8 BCD timekeeping registers with a 1 Hz advance, pending write buffer and transfer command.
//  Sits on the FPGA side of the bus; the top level merges data_out/data_oe into the DATA_ADDRESS inout.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per 1 s advance of the time registers (>=2)
//  SYNC_STAGES 2           synchronizer depth on all bus inputs (>=2)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  Reset       in   1  asynchronous, active-low reset
//  ChipSelect  in   1  bus chip select, active low
//  Read        in   1  bus read strobe, active low
//  Write       in   1  bus write strobe, active low; rising edge latches
//  AoD         in   1  0 = address phase, 1 = data phase
//  data_in     in   8  bus value sampled from DATA_ADDRESS
//  data_out    out  8  read data driven onto DATA_ADDRESS
//  data_oe     out  1  1 = drive DATA_ADDRESS with data_out
//  tick_1hz    out  1  one-cycle pulse on every seconds advance
//  proto_err   out  1  one-cycle pulse on illegal strobe combination
// BEHAVIOUR
//  Reset (async, Reset=0): addr_reg=8'h00, state=IDLE, data_out=8'h00, data_oe=0, tick_1hz=0, proto_err=0, prescaler=0.
//   Live and pending regs: sec/min/hr/yr=8'h00; date/month/dow/week=8'h01.
//   Reset mid-transaction aborts it. The next access needs a new address phase.
//  Inputs: ChipSelect, Read, Write, AoD, data_in pass through SYNC_STAGES flops. Edges are detected on synced signals.
//   Pin-to-action latency = SYNC_STAGES+1 clk.
//  FSM (synced signals):
//   IDLE     -> ADDR_PH  when CS=0 && AoD=0;  -> DATA_PH when CS=0 && AoD=1
//   ADDR_PH  : Write rising edge -> addr_reg <= data_in (value sampled with the synced Write=0 cycle); AoD=1 -> DATA_PH
//   DATA_PH  : Write rising -> register write (below); Read=0 -> READ_DRV; AoD=0 -> ADDR_PH
//   READ_DRV : data_oe=1, data_out=live[addr_reg] (8'h00 if unmapped), refreshed every cycle;
//              Read=1 -> DATA_PH, data_oe=0 next clk
//   Any state: CS=1 -> IDLE, data_oe=0 next clk, no write committed.
//   Read=0 && Write=0 while CS=0 -> proto_err pulse, no latch or drive, state unchanged.
//  Map: 8'h21 sec, 22 min, 23 hr, 24 date, 25 month, 26 year, 27 dow, 28 week (BCD).
//   8'hF0 = transfer command. All other addresses: write ignored, read 8'h00.
//  Writes to 8'h21-28 go to pending[] only. Reads always return live[].
//   Write to 8'hF0 (any data): live[] <= pending[] in one clk, prescaler <= 0, no tick that cycle.
//   If the transfer coincides with the prescaler terminal count, the transfer wins and the tick is dropped.
//  Tick: prescaler counts 0..TICK_DIV-1. At terminal: tick_1hz=1, sec increments.
//   Carry chain: sec 00-59 -> min 00-59 -> hr 00-23 -> date 01-31 and dow 01-07 (both on hr wrap).
//   date -> month 01-12 -> year 00-99. week 01-52 increments on dow 07->01.
//   Every month is 31 days.
//  BCD increment: low nibble 9 -> 0 with high carry. Value == max, or any non-BCD/out-of-range value written, wraps to min and carries.
//   Written values are stored as-is, without checking.
// STRUCTURE
//  rtc_pkg: address constants (ADDR_SEG..ADDR_WEEK, CMD_TRANSFER), reset values, per-field min/max, FSM state encoding.
//  Sub-module bcd_field_counter (params MIN, MAX): inputs load/load_val/inc, outputs value/carry.
//   Instantiated x8 with the carry chain in this module.
//  Synchronizer is an inline generate; no separate module.
// TESTING
//  1 Addr phase 8'h21, data write 8'h45, transfer write 8'hF0, read 8'h21 -> data_oe=1, data_out=8'h45.
//  2 Write 8'h23 = 8'h12, read 8'h23 without transfer -> 8'h00. After transfer -> 8'h12.
//  3 TICK_DIV=4, live = 23:59:59 date 31 month 12 year 99 dow 07 week 52, one tick ->
//    00:00:00, date 01, month 01, year 00, dow 01, week 01, tick_1hz pulse.
//  4 Drive Read=0 and Write=0 together with CS=0 -> proto_err pulse for 1 clk, data_oe stays 0, no register changes.
//  5 Drop CS mid data phase before Write rises -> no write, FSM IDLE. Reset=0 during READ_DRV -> data_oe=0 immediately.
//  6 Read unmapped 8'h50 -> 8'h00. Transfer issued on the prescaler terminal cycle -> no tick, prescaler=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus responder.
// Register map, field limits and FSM encoding.
package rtc_pkg;

  localparam logic [7:0] ADDR_SEG     = 8'h21;
  localparam logic [7:0] ADDR_MIN     = 8'h22;
  localparam logic [7:0] ADDR_HR      = 8'h23;
  localparam logic [7:0] ADDR_DATE    = 8'h24;
  localparam logic [7:0] ADDR_MONTH   = 8'h25;
  localparam logic [7:0] ADDR_YEAR    = 8'h26;
  localparam logic [7:0] ADDR_DOW     = 8'h27;
  localparam logic [7:0] ADDR_WEEK    = 8'h28;
  localparam logic [7:0] CMD_TRANSFER = 8'hF0;

  // index 0 = sec ... 7 = week; reset value equals MIN
  localparam logic [7:0][7:0] FIELD_MIN = {
    8'h01, 8'h01, 8'h00, 8'h01,
    8'h01, 8'h00, 8'h00, 8'h00
  };
  localparam logic [7:0][7:0] FIELD_MAX = {
    8'h52, 8'h07, 8'h99, 8'h12,
    8'h31, 8'h23, 8'h59, 8'h59
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_READ
  } state_t;

  function automatic logic in_map(
    input logic [7:0] a
  );
    return (a >= ADDR_SEG) && (a <= ADDR_WEEK);
  endfunction

  function automatic logic [2:0] field_idx(
    input logic [7:0] a
  );
    return 3'(a - ADDR_SEG);
  endfunction

endpackage

// File: rtl/rtc_bus_responder_bcd_field_counter.sv
// One BCD timekeeping field: load, increment, wrap and carry.
// Ports: clk, rst_n, load/load_val, inc -> value, carry.
module bcd_field_counter #(
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic wrap;

  // written values are unchecked, so anything
  // non-BCD or out of range rolls over like MAX
  always_comb begin
    wrap = (value == MAX)
        || (value[3:0] > 4'd9)
        || (value[7:4] > 4'd9)
        || (value > MAX)
        || (value < MIN);
  end

  assign carry = inc && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= MIN;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (wrap)
        value <= MIN;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= value + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC bus slave: synced strobes, addr/data FSM, BCD clock.
// Ports: clk, Reset, bus strobes, data_in/out/oe, tick_1hz, proto_err.
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ChipSelect,
  input  logic       Read,
  input  logic       Write,
  input  logic       AoD,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tick_1hz,
  output logic       proto_err
);

  localparam int SW = 12;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PTERM = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SYNC_RST = {4'b1110, 8'h00};

  logic [SW-1:0] pins;
  assign pins = {ChipSelect, Read, Write, AoD, data_in};

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic [SW-1:0] q;
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) q <= SYNC_RST;
        else        q <= pins;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) q <= SYNC_RST;
        else        q <= g_sync[g-1].q;
      end
    end
  end

  logic [SW-1:0] sv;
  assign sv = g_sync[SYNC_STAGES-1].q;

  logic       cs_s, rd_s, wr_s, aod_s;
  logic [7:0] din_s;
  assign {cs_s, rd_s, wr_s, aod_s, din_s} = sv;

  logic       wr_q, conflict_q;
  logic [7:0] din_q;
  logic       conflict, wr_rise;

  assign conflict = !cs_s && !rd_s && !wr_s;
  // a release out of a strobe clash is not a write
  assign wr_rise  = wr_s && !wr_q && !conflict_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_q       <= 1'b1;
      conflict_q <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      wr_q       <= wr_s;
      conflict_q <= conflict;
      din_q      <= din_s;
    end
  end

  state_t     state;
  logic [7:0] addr_reg;
  logic       commit, xfer, pend_we;

  assign commit  = !cs_s && (state == ST_DATA) && wr_rise;
  assign xfer    = commit && (addr_reg == CMD_TRANSFER);
  assign pend_we = commit && in_map(addr_reg);

  logic [7:0] pend [8];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) pend[i] <= FIELD_MIN[i];
    end else if (pend_we) begin
      pend[field_idx(addr_reg)] <= din_q;
    end
  end

  logic [PW-1:0] presc;
  logic          tick_int;

  // transfer wins over a coinciding terminal count
  assign tick_int = (presc == PTERM) && !xfer;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      presc    <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= tick_int;
      if (xfer || presc == PTERM) presc <= '0;
      else                        presc <= presc + 1'b1;
    end
  end

  logic [7:0][7:0] live;
  logic [7:0]      inc_v, cy;

  // sec>min>hr; hr wrap feeds date and dow
  assign inc_v = {cy[6], cy[2], cy[4], cy[3],
                  cy[2], cy[1], cy[0], tick_int};

  logic unused_cy;
  assign unused_cy = cy[5] ^ cy[7];

  for (genvar i = 0; i < 8; i++) begin : g_fld
    bcd_field_counter #(
      .MIN(FIELD_MIN[i]),
      .MAX(FIELD_MAX[i])
    ) u_fld (
      .clk     (clk),
      .rst_n   (Reset),
      .load    (xfer),
      .load_val(pend[i]),
      .inc     (inc_v[i]),
      .value   (live[i]),
      .carry   (cy[i])
    );
  end

  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (in_map(addr_reg)) rd_val = live[field_idx(addr_reg)];
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      addr_reg  <= 8'h00;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= conflict && !conflict_q;
      if (cs_s) begin
        state   <= ST_IDLE;
        data_oe <= 1'b0;
      end else if (conflict) begin
        data_oe <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: state <= aod_s ? ST_DATA : ST_ADDR;
          ST_ADDR: begin
            if (wr_rise) addr_reg <= din_q;
            if (aod_s)   state    <= ST_DATA;
          end
          ST_DATA: begin
            if (wr_rise) begin
              state <= ST_DATA;
            end else if (!rd_s) begin
              state    <= ST_READ;
              data_oe  <= 1'b1;
              data_out <= rd_val;
            end else if (!aod_s) begin
              state <= ST_ADDR;
            end
          end
          ST_READ: begin
            if (rd_s) begin
              state   <= ST_DATA;
              data_oe <= 1'b0;
            end else begin
              data_oe  <= 1'b1;
              data_out <= rd_val;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: random BCD times vs a
// calendar model, bus protocol corners and tick timing.
module tb_rtc_bus_responder;

  localparam int TD = 400;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, aod = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       doe, tick, perr;

  rtc_bus_responder #(
    .TICK_DIV(TD),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .Reset     (rst_n),
    .ChipSelect(cs),
    .Read      (rd),
    .Write     (wr),
    .AoD       (aod),
    .data_in   (din),
    .data_out  (dout),
    .data_oe   (doe),
    .tick_1hz  (tick),
    .proto_err (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tick = 0, n_perr = 0, n_oe = 0, last_tick = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tick) begin
      n_tick++;
      last_tick = cyc;
    end
    if (perr) n_perr++;
    if (doe)  n_oe++;
  end

  initial begin
    #600_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // calendar model
  int fmin [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  int fmax [8] = '{59, 59, 23, 31, 12, 99, 7, 52};
  logic [7:0] live_m [8];
  logic [7:0] pend_m [8];

  function automatic logic [7:0] i2b(int n);
    logic [3:0] h, l;
    h = 4'(n / 10);
    l = 4'(n % 10);
    return {h, l};
  endfunction

  function automatic bit bump(int i);
    logic [7:0] v;
    int n;
    v = live_m[i];
    n = v[7:4] * 10 + v[3:0];
    if (v[3:0] > 9 || v[7:4] > 9 ||
        n < fmin[i] || n >= fmax[i]) begin
      live_m[i] = i2b(fmin[i]);
      return 1'b1;
    end
    live_m[i] = i2b(n + 1);
    return 1'b0;
  endfunction

  function automatic void advance();
    if (bump(0) && bump(1) && bump(2)) begin
      if (bump(3) && bump(4)) void'(bump(5));
      if (bump(6)) void'(bump(7));
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      live_m[i] = i2b(fmin[i]);
      pend_m[i] = i2b(fmin[i]);
    end
  endfunction

  function automatic logic [7:0] exp_read(logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h28) return live_m[a - 8'h21];
    return 8'h00;
  endfunction

  // bus tasks
  int last_wr = 0, xfer_cyc = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_addr(input logic [7:0] a);
    cs = 0; aod = 0; din = a; wr = 0;
    step(3);
    wr = 1;
    step(3);
  endtask

  task automatic bus_data(input logic [7:0] d);
    aod = 1; din = d;
    step(3);
    wr = 0;
    step(3);
    wr = 1;
    last_wr = cyc;
    step(3);
  endtask

  task automatic reg_write(input logic [7:0] a,
                           input logic [7:0] d);
    bus_addr(a);
    bus_data(d);
    if (a >= 8'h21 && a <= 8'h28) pend_m[a - 8'h21] = d;
  endtask

  task automatic transfer();
    bus_addr(8'hF0);
    bus_data(8'($urandom));
    xfer_cyc = last_wr + LAT;
    for (int i = 0; i < 8; i++) live_m[i] = pend_m[i];
  endtask

  task automatic check_read(input string tag,
                            input logic [7:0] a);
    logic [7:0] v;
    logic o1, o2;
    bus_addr(a);
    aod = 1;
    step(3);
    rd = 0;
    step(3);
    v = dout;
    o1 = doe;
    rd = 1;
    step(3);
    o2 = doe;
    chk({tag, "_oe"}, 32'(o1), 32'd1);
    chk(tag, 32'(v), 32'(exp_read(a)));
    chk({tag, "_oe_off"}, 32'(o2), 32'd0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++)
      check_read($sformatf("%s_f%0d", tag, i), 8'(8'h21 + i));
  endtask

  function automatic logic [7:0] rnd_field(int i);
    if ($urandom_range(0, 2) == 0) return i2b(fmax[i]);
    return i2b(int'($urandom_range(fmin[i], fmax[i])));
  endfunction

  initial begin
    int n0, p0, o0;
    logic [7:0] tv [8];
    model_reset();

    // reset state
    step(3);
    chk("rst_oe", 32'(doe), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    rst_n = 1;
    read_all("rst");

    // pending write, transfer, read back
    reg_write(8'h21, 8'h45);
    transfer();
    check_read("t1_sec", 8'h21);

    // reads return live, not pending
    reg_write(8'h23, 8'h12);
    check_read("t2_pre", 8'h23);
    transfer();
    check_read("t2_post", 8'h23);

    // unmapped address
    check_read("t6_unm", 8'h50);
    reg_write(8'h50, 8'h77);
    check_read("t6_unm2", 8'h50);

    // strobe clash
    bus_addr(8'h21);
    aod = 1;
    step(3);
    n0 = n_perr;
    o0 = n_oe;
    din = 8'h99;
    rd = 0; wr = 0;
    step(1);
    rd = 1; wr = 1;
    step(6);
    chk("t4_perr_cnt", 32'(n_perr - n0), 32'd1);
    chk("t4_oe_cnt", 32'(n_oe - o0), 32'd0);
    transfer();
    check_read("t4_sec", 8'h21);

    // CS dropped before Write rises
    bus_addr(8'h22);
    aod = 1; din = 8'h33;
    step(3);
    wr = 0;
    step(1);
    cs = 1;
    step(3);
    wr = 1;
    step(3);
    transfer();
    check_read("t5_min", 8'h22);

    // reset while driving
    bus_addr(8'h21);
    aod = 1;
    step(3);
    rd = 0;
    step(3);
    chk("t5_drv_oe", 32'(doe), 32'd1);
    #1 rst_n = 0;
    #1 chk("t5_rst_oe", 32'(doe), 32'd0);
    cs = 1; rd = 1; wr = 1; aod = 0;
    model_reset();
    step(2);
    rst_n = 1;
    check_read("t5_after_rst", 8'h21);
    check_read("t5_after_rst_hr", 8'h23);

    // one-second advance on random and corner times
    for (int it = 0; it < 6; it++) begin
      if (it == 0)
        tv = '{8'h59, 8'h59, 8'h23, 8'h31,
               8'h12, 8'h99, 8'h07, 8'h52};
      else if (it == 1)
        tv = '{8'h5A, 8'h59, 8'h2F, 8'h15,
               8'h06, 8'h42, 8'h0C, 8'h10};
      else
        for (int i = 0; i < 8; i++) tv[i] = rnd_field(i);
      for (int i = 0; i < 8; i++)
        reg_write(8'(8'h21 + i), tv[i]);
      transfer();
      n0 = n_tick;
      read_all($sformatf("ld%0d", it));
      while (n_tick == n0 && cyc < xfer_cyc + TD + 20)
        step(1);
      step(2);
      chk($sformatf("tick_cnt%0d", it),
          32'(n_tick - n0), 32'd1);
      chk($sformatf("tick_cyc%0d", it),
          32'(last_tick), 32'(xfer_cyc + TD));
      advance();
      read_all($sformatf("adv%0d", it));
    end

    // transfer on the terminal-count cycle
    transfer();
    p0 = xfer_cyc;
    wr = 0;
    while (cyc < p0 + TD - LAT) step(1);
    wr = 1;
    n0 = n_tick;
    step(3);
    xfer_cyc = p0 + TD;
    for (int i = 0; i < 8; i++) live_m[i] = pend_m[i];
    while (cyc < xfer_cyc + TD + 2) step(1);
    chk("t6_coll_cnt", 32'(n_tick - n0), 32'd1);
    chk("t6_coll_cyc", 32'(last_tick), 32'(xfer_cyc + TD));
    advance();
    check_read("t6_coll_sec", 8'h21);
    check_read("t6_coll_min", 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
